// File: rtl/ibex_instr_wb_pkg.sv
// Shared types and constants for the instruction-side Wishbone bridge.
package ibex_instr_wb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } wb_state_e;

  localparam logic [3:0]  WB_SEL_ALL = 4'hF;
  localparam int unsigned ADDR_W     = 30;

endpackage

// File: rtl/ibex_instr_wb_addr_fifo.sv
// Circular queue of granted word addresses; pointers wrap modulo DEPTH so any depth works.
module ibex_instr_wb_addr_fifo
  import ibex_instr_wb_pkg::*;
#(
  parameter  int unsigned DEPTH = 2,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1),
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              push_i,
  input  logic [ADDR_W-1:0] push_addr_i,
  input  logic              pop_i,
  output logic [ADDR_W-1:0] head_o,
  output logic [ADDR_W-1:0] head_next_o,
  output logic [CNT_W-1:0]  count_o
);

  logic [ADDR_W-1:0] mem_q [DEPTH];
  logic [ADDR_W-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
    logic [PTR_W-1:0] nxt;
    if (ptr == PTR_W'(DEPTH - 1)) begin
      nxt = '0;
    end else begin
      nxt = ptr + 1'b1;
    end
    return nxt;
  endfunction

  // Queue bookkeeping: write at tail, read at head, count tracks push minus pop.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_i) begin
      mem_d[wr_ptr_q] = push_addr_i;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_i) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Head seen after a pop: the next stored entry, or the address being pushed right now.
  always_comb begin
    if (count_q > CNT_W'(1)) begin
      head_next_o = mem_q[ptr_inc(rd_ptr_q)];
    end else begin
      head_next_o = push_addr_i;
    end
  end

  // Queue state registers.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/ibex_instr_wb_bridge.sv
// Core instruction req/gnt/rvalid to Wishbone classic read bridge, one bus cycle at a time.
// Optional bus watchdog enabled by defining WB_TIMEOUT_EN.
module ibex_instr_wb_bridge
  import ibex_instr_wb_pkg::*;
#(
  parameter int unsigned ADDR_DEPTH     = 2,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        instr_req_i,
  output logic        instr_gnt_o,
  input  logic [31:0] instr_addr_i,
  output logic        instr_rvalid_o,
  output logic [31:0] instr_rdata_o,
  output logic        instr_err_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [3:0]  wb_sel_o,
  output logic [31:0] wb_adr_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i,
  input  logic        wb_err_i
);

  localparam int unsigned CNT_W = $clog2(ADDR_DEPTH + 1);

  wb_state_e         state_q, state_d;
  logic              cyc_q, cyc_d;
  logic [31:0]       adr_q, adr_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              err_q, err_d;
  logic              rvalid_q, rvalid_d;

  logic              gnt_s;
  logic              pop_s;
  logic              tmo_hit_s;
  logic              bus_err_s;
  logic              bus_done_s;
  logic [CNT_W-1:0]  count_s;
  logic [ADDR_W-1:0] head_s;
  logic [ADDR_W-1:0] head_next_s;
  logic              unused_addr_s;

  // Only the registered count gates the grant; a pop in the same cycle does not free a slot.
  assign gnt_s = rst_ni & instr_req_i & (count_s < CNT_W'(ADDR_DEPTH));
  assign pop_s = (state_q == RESP);

  assign unused_addr_s = ^instr_addr_i[1:0];

  ibex_instr_wb_addr_fifo #(
    .DEPTH (ADDR_DEPTH)
  ) u_addr_fifo (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .push_i      (gnt_s),
    .push_addr_i (instr_addr_i[31:2]),
    .pop_i       (pop_s),
    .head_o      (head_s),
    .head_next_o (head_next_s),
    .count_o     (count_s)
  );

`ifdef WB_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TMO_W-1:0] tmo_q, tmo_d;

  // Watchdog counts silent BUS cycles; it idles at zero so every bus cycle starts fresh.
  always_comb begin
    tmo_d     = tmo_q;
    tmo_hit_s = 1'b0;
    if ((state_q == BUS) && !(wb_ack_i || wb_err_i)) begin
      tmo_d     = tmo_q + 1'b1;
      tmo_hit_s = (tmo_d == TMO_W'(TIMEOUT_CYCLES));
    end else begin
      tmo_d = '0;
    end
  end

  // Watchdog register.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      tmo_q <= '0;
    end else begin
      tmo_q <= tmo_d;
    end
  end
`else
  logic unused_tmo_s;

  assign tmo_hit_s    = 1'b0;
  assign unused_tmo_s = (TIMEOUT_CYCLES == 32'd0);
`endif

  // Error (or watchdog expiry) beats a simultaneous ack.
  assign bus_err_s  = wb_err_i | tmo_hit_s;
  assign bus_done_s = wb_ack_i | bus_err_s;

  // Next-state and registered-output logic of the bus FSM.
  always_comb begin
    state_d  = state_q;
    cyc_d    = cyc_q;
    adr_d    = adr_q;
    rdata_d  = rdata_q;
    err_d    = 1'b0;
    rvalid_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (count_s != CNT_W'(0)) begin
          state_d = BUS;
          cyc_d   = 1'b1;
          adr_d   = {head_s, 2'b00};
        end else begin
          cyc_d = 1'b0;
        end
      end
      BUS: begin
        if (bus_done_s) begin
          state_d  = RESP;
          cyc_d    = 1'b0;
          rvalid_d = 1'b1;
          err_d    = bus_err_s;
          rdata_d  = bus_err_s ? 32'h0000_0000 : wb_dat_i;
        end else begin
          cyc_d = 1'b1;
        end
      end
      RESP: begin
        if ((count_s > CNT_W'(1)) || gnt_s) begin
          state_d = BUS;
          cyc_d   = 1'b1;
          adr_d   = {head_next_s, 2'b00};
        end else begin
          state_d = IDLE;
          cyc_d   = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        cyc_d   = 1'b0;
      end
    endcase
  end

  // FSM state and output registers.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      cyc_q    <= 1'b0;
      adr_q    <= 32'h0000_0000;
      rdata_q  <= 32'h0000_0000;
      err_q    <= 1'b0;
      rvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cyc_q    <= cyc_d;
      adr_q    <= adr_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
      rvalid_q <= rvalid_d;
    end
  end

  assign instr_gnt_o    = gnt_s;
  assign instr_rvalid_o = rvalid_q;
  assign instr_rdata_o  = rdata_q;
  assign instr_err_o    = err_q;
  assign wb_cyc_o       = cyc_q;
  assign wb_stb_o       = cyc_q;
  assign wb_we_o        = 1'b0;
  assign wb_sel_o       = WB_SEL_ALL;
  assign wb_adr_o       = adr_q;

endmodule

// File: tb/tb_ibex_instr_wb_bridge.sv
// Self-checking bench for ibex_instr_wb_bridge: directed scenarios plus random traffic against a
// queue-based reference model. Define WB_TIMEOUT_EN to exercise the watchdog build.
module tb_ibex_instr_wb_bridge;

  localparam int DEPTH = 2;
  localparam int TMO   = 8;
  localparam logic [31:0] KEY = 32'hA5A5_5A5A;
`ifdef WB_TIMEOUT_EN
  localparam int EXP_RUN = TMO;
`else
  localparam int EXP_RUN = 20;
`endif

  logic        clk = 1'b0;
  logic        rst_n, req, ack, err;
  logic [31:0] addr, dat;
  logic        gnt, rvalid, rerr, cyc, stb, we;
  logic [31:0] rdata, adr;
  logic [3:0]  sel;

  ibex_instr_wb_bridge #(.ADDR_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)) dut (
    .clk_i(clk), .rst_ni(rst_n), .instr_req_i(req), .instr_gnt_o(gnt), .instr_addr_i(addr),
    .instr_rvalid_o(rvalid), .instr_rdata_o(rdata), .instr_err_o(rerr),
    .wb_cyc_o(cyc), .wb_stb_o(stb), .wb_we_o(we), .wb_sel_o(sel), .wb_adr_o(adr),
    .wb_dat_i(dat), .wb_ack_i(ack), .wb_err_i(err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  // reference model: granted-unanswered addresses and the response due next cycle
  logic [29:0] pend[$];
  bit          rsp_due = 1'b0;
  bit          rsp_err = 1'b0;
  logic [31:0] rsp_data = 32'h0;
  logic [31:0] last_data = 32'h0;
  bit          prev_ne = 1'b0;
  int          bus_cnt = 0;
  int          stb_run = 0;
  bit          s_gnt, s_rvalid, s_stb;
  logic [31:0] rv_q[$];
  logic        rv_err_q[$];

  // directed-test scratch
  int  first_rv, gnt_cyc, run, len, gap;
  bit  seen, first;
  bit  hist[80];
  int  runs[$];
  int  gaps[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at a negedge with inputs already set: checks this cycle, then advances one clock.
  task automatic cycle();
    bit          exp_gnt, exp_stb, ne, nxt_due, nxt_err, rst_now;
    logic [31:0] nxt_data;
    #1;
    s_gnt    = gnt;
    s_rvalid = rvalid;
    s_stb    = stb;
    rst_now  = (rst_n !== 1'b1);
    exp_gnt  = !rst_now && (req === 1'b1) && (pend.size() < DEPTH);
    ne       = (pend.size() > 0);
    exp_stb  = ne && prev_ne && !rsp_due;
    if (chk_en) begin
      check("gnt", gnt, exp_gnt);
      check("stb_eq_cyc", stb, cyc);
      check("we", we, 1'b0);
      check("sel", sel, 4'hF);
      check("stb", stb, exp_stb);
      if (exp_stb) check("adr", adr, {pend[0], 2'b00});
      check("rvalid", rvalid, rsp_due);
      check("rerr", rerr, rsp_due ? rsp_err : 1'b0);
      check("rdata", rdata, rsp_due ? rsp_data : last_data);
    end
    if (rvalid === 1'b1) begin
      rv_q.push_back(rdata);
      rv_err_q.push_back(rerr);
    end
    nxt_due  = 1'b0;
    nxt_err  = 1'b0;
    nxt_data = 32'h0;
    if (stb === 1'b1) begin
      if (ack || err) begin
        nxt_due  = 1'b1;
        nxt_err  = err;
        nxt_data = err ? 32'h0 : dat;
        bus_cnt  = 0;
      end else begin
`ifdef WB_TIMEOUT_EN
        bus_cnt++;
        if (bus_cnt == TMO) begin
          nxt_due = 1'b1;
          nxt_err = 1'b1;
          bus_cnt = 0;
        end
`endif
      end
    end else begin
      bus_cnt = 0;
    end
    @(posedge clk);
    if (rst_now) begin
      pend.delete();
      rsp_due   = 1'b0;
      last_data = 32'h0;
      bus_cnt   = 0;
      prev_ne   = 1'b0;
    end else begin
      prev_ne = ne;
      if (rsp_due) begin
        last_data = rsp_data;
        void'(pend.pop_front());
      end
      if (exp_gnt) pend.push_back(addr[31:2]);
      rsp_due  = nxt_due;
      rsp_err  = nxt_err;
      rsp_data = nxt_data;
    end
    @(negedge clk);
  endtask

  // Slave that acks in the hold-th cycle of a strobe, data derived from the address.
  task automatic slave_set(input int hold);
    if (stb === 1'b1) begin
      stb_run++;
      ack = (stb_run >= hold);
    end else begin
      stb_run = 0;
      ack     = 1'b0;
    end
    err = 1'b0;
    dat = adr ^ KEY;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; req = 1'b0; ack = 1'b0; err = 1'b0; addr = 32'h0; dat = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_en = 1'b1;

    // reset state; gnt forced low while in reset
    req = 1'b1; addr = 32'h0000_0040;
    cycle();
    check("rst_gnt", s_gnt, 1'b0);
    check("rst_stb", stb, 1'b0);
    check("rst_rvalid", rvalid, 1'b0);
    check("rst_rdata", rdata, 32'h0);
    check("rst_adr", adr, 32'h0);
    req = 1'b0; rst_n = 1'b1;
    cycle();

    // 1: single fetch, zero-wait slave
    rv_q.delete();
    req = 1'b1; addr = 32'h0000_1002;
    cycle();
    req = 1'b0;
    check("t1_stb_n1", stb, 1'b0);
    cycle();
    check("t1_stb_n2", stb, 1'b1);
    check("t1_adr", adr, 32'h0000_1000);
    ack = 1'b1; dat = 32'hDEAD_BEEF;
    cycle();
    ack = 1'b0;
    check("t1_rvalid", rvalid, 1'b1);
    check("t1_rdata", rdata, 32'hDEAD_BEEF);
    check("t1_err", rerr, 1'b0);
    cycle();
    check("t1_one_rvalid", rv_q.size(), 32'd1);

    // 2: two outstanding, third held until a slot frees
    rv_q.delete();
    req = 1'b1; addr = 32'h100; cycle();
    addr = 32'h104; cycle();
    addr = 32'h108;
    first_rv = -1; gnt_cyc = -1;
    for (int i = 0; i < 40; i++) begin
      slave_set(1);
      cycle();
      if (s_rvalid && first_rv < 0) first_rv = i;
      if (req && s_gnt) begin
        gnt_cyc = i;
        req = 1'b0;
      end
    end
    ack = 1'b0;
    check("t2_gnt_after_resp", gnt_cyc, first_rv + 1);
    check("t2_nrsp", rv_q.size(), 32'd3);
    if (rv_q.size() >= 2) begin
      check("t2_rsp0", rv_q[0], 32'h100 ^ KEY);
      check("t2_rsp1", rv_q[1], 32'h104 ^ KEY);
    end

    // 3: bus error with ack, then a normal transfer
    rv_q.delete(); rv_err_q.delete();
    req = 1'b1; addr = 32'h200; cycle();
    addr = 32'h204; cycle();
    req = 1'b0;
    first = 1'b1;
    for (int i = 0; i < 12; i++) begin
      slave_set(1);
      if (first && stb === 1'b1) begin
        err = 1'b1; dat = 32'hFFFF_FFFF; first = 1'b0;
      end
      cycle();
      err = 1'b0;
    end
    ack = 1'b0;
    check("t3_nrsp", rv_q.size(), 32'd2);
    if (rv_q.size() >= 2) begin
      check("t3_err0", rv_err_q[0], 1'b1);
      check("t3_data0", rv_q[0], 32'h0);
      check("t3_err1", rv_err_q[1], 1'b0);
      check("t3_data1", rv_q[1], 32'h204 ^ KEY);
    end

    // 4: reset while strobing with two queued
    rv_q.delete();
    req = 1'b1; addr = 32'h300; cycle();
    addr = 32'h304; cycle();
    req = 1'b0;
    for (int i = 0; i < 10 && stb !== 1'b1; i++) cycle();
    check("t4_stb_up", stb, 1'b1);
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    check("t4_stb_drop", stb, 1'b0);
    check("t4_cyc_drop", cyc, 1'b0);
    repeat (5) cycle();
    check("t4_no_rvalid", rv_q.size(), 32'd0);
    req = 1'b1; addr = 32'h400;
    cycle();
    check("t4_gnt_after", s_gnt, 1'b1);
    req = 1'b0;
    for (int i = 0; i < 10; i++) begin
      slave_set(1);
      cycle();
    end
    ack = 1'b0;
    check("t4_nrsp", rv_q.size(), 32'd1);
    if (rv_q.size() >= 1) check("t4_data", rv_q[0], 32'h400 ^ KEY);

    // 5: slow slave with a grant arriving mid-transfer
    rv_q.delete();
    req = 1'b1; addr = 32'h500; cycle();
    req = 1'b0;
    for (int i = 0; i < 80; i++) begin
      slave_set(20);
      if (i == 5) begin
        req = 1'b1; addr = 32'h504;
      end
      cycle();
      hist[i] = s_stb;
      if (req && s_gnt) req = 1'b0;
    end
    ack = 1'b0;
    runs.delete(); gaps.delete();
    len = 0; gap = 0; seen = 1'b0;
    for (int i = 0; i < 80; i++) begin
      if (hist[i]) begin
        if (len == 0 && seen) gaps.push_back(gap);
        len++;
      end else begin
        if (len > 0) begin
          runs.push_back(len);
          len = 0; seen = 1'b1; gap = 0;
        end
        gap++;
      end
    end
    check("t5_nruns", runs.size(), 32'd2);
    if (runs.size() >= 2 && gaps.size() >= 1) begin
      check("t5_run0", runs[0], EXP_RUN);
      check("t5_run1", runs[1], EXP_RUN);
      check("t5_gap", gaps[0], 32'd1);
    end
    check("t5_nrsp", rv_q.size(), 32'd2);

    // 6: slave never answers
    rv_q.delete(); rv_err_q.delete();
    ack = 1'b0; err = 1'b0;
    req = 1'b1; addr = 32'h600; cycle();
    req = 1'b0;
    run = 0;
    for (int i = 0; i < 150; i++) begin
      cycle();
      if (s_stb) run++;
    end
`ifdef WB_TIMEOUT_EN
    check("t6_run", run, TMO);
    check("t6_nrsp", rv_q.size(), 32'd1);
    if (rv_q.size() >= 1) begin
      check("t6_err", rv_err_q[0], 1'b1);
      check("t6_data", rv_q[0], 32'h0);
    end
`else
    check("t6_run_long", run >= 100, 1'b1);
    check("t6_nrsp", rv_q.size(), 32'd0);
    rst_n = 1'b0; cycle();
    rst_n = 1'b1; cycle();
`endif

    // random traffic against the model
    for (int i = 0; i < 800; i++) begin
      req   = ($urandom_range(0, 1) == 1);
      addr  = $urandom;
      rst_n = ($urandom_range(0, 199) != 0);
      if (stb === 1'b1) begin
        ack = ($urandom_range(0, 2) == 0);
        err = ($urandom_range(0, 9) == 0);
      end else begin
        ack = ($urandom_range(0, 15) == 0);
        err = 1'b0;
      end
      dat = $urandom;
      cycle();
    end
    rst_n = 1'b1; req = 1'b0;
    for (int i = 0; i < 40; i++) begin
      slave_set(1);
      cycle();
    end
    ack = 1'b0;
    check("drain_stb", stb, 1'b0);
    check("drain_rvalid", rvalid, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
